mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory-access (4th) stage of the 5-stage multi-phase RV32I core; sits between execute and writeback.
- Performs loads/stores against an internal word-organised data memory.
- Maps the hardware-counter address to a read-only input and ignores stores to the UART address (the UART is driven outside this block).
- Registers next-PC, destination register, write-enable and result for writeback.

Parameters:
- DMEM_WORDS, 16384, number of 32-bit data-memory words (power of two).
- DMEM_AW, 14, word-index width (log2 DMEM_WORDS).

Ports:
- clk  in  1  stage clock (mclk phase pulse from the core sequencer)
- reset  in  1  asynchronous active-low reset
- info_load  in  3  load kind (package encoding)
- info_store  in  2  store kind (package encoding)
- alu_result  in  32  effective address or ALU result
- rs2  in  32  store data
- write_reg  in  1  destination write enable from execute
- dst_addr  in  5  destination register number
- next_pc  in  32  next PC computed by execute
- hc_OUT_data  in  32  hardware counter value
- next_pcD  out  32  registered next_pc
- w_reg  out  1  registered write_reg
- rd_data  out  32  registered writeback data
- branchD  out  32  registered alu_result (address/ALU pass-through)
- dst_addrD  out  5  registered dst_addr

Behaviour:
- reset low (async): next_pcD, w_reg, rd_data, branchD, dst_addrD = 0. No memory write while reset is low. Memory contents are not cleared.
- All outputs update on posedge clk; latency is 1 clk from inputs to outputs.
- Pass-through registers: next_pcD<=next_pc, w_reg<=write_reg, dst_addrD<=dst_addr, branchD<=alu_result.
- Word index = alu_result[DMEM_AW+1:2]; higher address bits are ignored, so addresses wrap modulo memory size.
- Loads (info_load != NOTLOAD):
  - Read is combinational from the array; the result is registered into rd_data.
  - LB/LBU: lane alu_result[1:0]; LH/LHU: half alu_result[1]. alu_result[0] is ignored for halfwords; alu_result[1:0] is ignored for LW.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - If alu_result == HARDWARE_COUNTER_ADDR, rd_data <= hc_OUT_data unmodified, for any load kind.
- Non-load: rd_data <= alu_result.
- Stores (info_store != NOTSTORE), written at posedge clk:
  - SB writes byte lane alu_result[1:0] with rs2[7:0].
  - SH writes half alu_result[1] with rs2[15:0].
  - SW writes the whole word.
  - Other lanes are preserved.
- A store to UART_ADDR or HARDWARE_COUNTER_ADDR does not modify memory.
- Same-edge load and store: the load returns the old (pre-write) contents.
- Undefined info_load codes behave as NOTLOAD. Undefined info_store codes behave as NOTSTORE.
- Store and load in the same cycle do not occur from the decoder; if both are asserted, both act as specified.

Decomposition:
- Shared package / define file (alongside 99_define.v):
  - NOTLOAD=0, LB=1, LH=2, LW=3, LBU=4, LHU=5
  - NOTSTORE=0, SB=1, SH=2, SW=3
  - UART_ADDR=32'hF6FF_F070
  - HARDWARE_COUNTER_ADDR=32'hFFFF_FF00
- One natural sub-module: dmem_array (byte-enable write, async read, DMEM_WORDS×32).
- Load extraction/extension and pipeline registers stay in the top.

Test Plan:
- Reset asserted mid-operation with outputs nonzero -> all outputs become 0 immediately, without a clk edge; an SW presented during reset leaves memory unchanged.
- SW 0xDEADBEEF to 0x100, then LW 0x100 -> rd_data=0xDEADBEEF; then LB 0x103 -> 0xFFFFFFDE; LBU 0x103 -> 0x000000DE; LH 0x102 -> 0xFFFFDEAD; LHU 0x100 -> 0x0000BEEF.
- SB 0x5A to 0x101 over 0xDEADBEEF, then LW 0x100 -> 0xDEAD5AEF. SH 0x1234 to 0x102, then LW -> 0x12345AEF.
- Non-load, alu_result=0x00000042, write_reg=1, dst_addr=7, next_pc=0x2004 -> rd_data=0x42, w_reg=1, dst_addrD=7, next_pcD=0x2004, branchD=0x42 after one clk.
- LW from 0xFFFFFF00 with hc_OUT_data=0x00001234 -> rd_data=0x00001234. SW to 0xF6FFF070 -> memory word at index (0xF6FFF070>>2 mod DMEM_WORDS) unchanged.
- Wrap: SW 0xA5A5A5A5 to address DMEM_WORDS*4 -> LW 0x0 returns 0xA5A5A5A5.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_stage_pkg
//  Brief    : Load/store kind encodings and special I/O addresses shared by
//             the memory-access stage and its data memory.
//  Revision : 1.0
// ============================================================================
package mem_access_stage_pkg;

    typedef enum logic [2:0] {
        NOTLOAD = 3'd0,
        LB      = 3'd1,
        LH      = 3'd2,
        LW      = 3'd3,
        LBU     = 3'd4,
        LHU     = 3'd5
    } load_kind_e;

    typedef enum logic [1:0] {
        NOTSTORE = 2'd0,
        SB       = 2'd1,
        SH       = 2'd2,
        SW       = 2'd3
    } store_kind_e;

    localparam logic [31:0] UART_ADDR             = 32'hF6FF_F070;
    localparam logic [31:0] HARDWARE_COUNTER_ADDR = 32'hFFFF_FF00;

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_dmem_array.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_stage_dmem_array
//  Brief    : Word-organised data memory, per-byte write enables, async read.
//  Revision : 1.0
// ============================================================================
module mem_access_stage_dmem_array #(
    parameter int DMEM_WORDS = 16384,
    parameter int DMEM_AW    = 14
) (
    input  logic               clk,
    input  logic [3:0]         we,
    input  logic [DMEM_AW-1:0] addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata
);

    logic [31:0] r_mem [DMEM_WORDS];

    // Contents are intentionally never reset; only enabled lanes change.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_stage
//  Brief    : RV32I memory-access stage: data-memory loads/stores, hardware
//             counter read-back, and registered hand-off to writeback.
//  Revision : 1.0
// ============================================================================
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DMEM_WORDS = 16384,
    parameter int DMEM_AW    = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  info_load,
    input  logic [1:0]  info_store,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2,
    input  logic        write_reg,
    input  logic [4:0]  dst_addr,
    input  logic [31:0] next_pc,
    input  logic [31:0] hc_OUT_data,
    output logic [31:0] next_pcD,
    output logic        w_reg,
    output logic [31:0] rd_data,
    output logic [31:0] branchD,
    output logic [4:0]  dst_addrD
);

    logic [DMEM_AW-1:0] w_word_idx;
    logic               w_is_hc;
    logic               w_is_uart;
    logic [3:0]         w_be;
    logic [3:0]         w_we;
    logic [31:0]        w_wdata;
    logic [31:0]        w_rdata;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_rd_next;

    logic [31:0]        r_next_pc;
    logic               r_w_reg;
    logic [31:0]        r_rd_data;
    logic [31:0]        r_branch;
    logic [4:0]         r_dst_addr;

    assign w_word_idx = alu_result[DMEM_AW+1:2];
    assign w_is_hc    = (alu_result == HARDWARE_COUNTER_ADDR);
    assign w_is_uart  = (alu_result == UART_ADDR);

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = rs2;
        case (info_store)
            SB: begin
                w_be    = 4'b0001 << alu_result[1:0];
                w_wdata = {4{rs2[7:0]}};
            end
            SH: begin
                w_be    = alu_result[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{rs2[15:0]}};
            end
            SW:      w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // Memory-mapped I/O addresses never alias into the array; reset blocks writes.
    assign w_we = (w_is_hc || w_is_uart || !reset) ? 4'b0000 : w_be;

    mem_access_stage_dmem_array #(
        .DMEM_WORDS (DMEM_WORDS),
        .DMEM_AW    (DMEM_AW)
    ) u_dmem (
        .clk   (clk),
        .we    (w_we),
        .addr  (w_word_idx),
        .wdata (w_wdata),
        .rdata (w_rdata)
    );

    assign w_byte = w_rdata[{alu_result[1:0], 3'b000} +: 8];
    assign w_half = alu_result[1] ? w_rdata[31:16] : w_rdata[15:0];

    always_comb begin
        w_rd_next = alu_result;
        case (info_load)
            LB:      w_rd_next = {{24{w_byte[7]}}, w_byte};
            LH:      w_rd_next = {{16{w_half[15]}}, w_half};
            LW:      w_rd_next = w_rdata;
            LBU:     w_rd_next = {24'h0, w_byte};
            LHU:     w_rd_next = {16'h0, w_half};
            default: w_rd_next = alu_result;
        endcase
        if (w_is_hc && (info_load inside {LB, LH, LW, LBU, LHU})) begin
            w_rd_next = hc_OUT_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_next_pc  <= 32'h0;
            r_w_reg    <= 1'b0;
            r_rd_data  <= 32'h0;
            r_branch   <= 32'h0;
            r_dst_addr <= 5'h0;
        end else begin
            r_next_pc  <= next_pc;
            r_w_reg    <= write_reg;
            r_rd_data  <= w_rd_next;
            r_branch   <= alu_result;
            r_dst_addr <= dst_addr;
        end
    end

    assign next_pcD  = r_next_pc;
    assign w_reg     = r_w_reg;
    assign rd_data   = r_rd_data;
    assign branchD   = r_branch;
    assign dst_addrD = r_dst_addr;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_stage
//  Brief    : Directed table-driven bench for mem_access_stage.
//  Revision : 1.0
// ============================================================================
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    localparam int DMEM_WORDS = 16384;
    localparam int DMEM_AW    = 14;

    logic        clk;
    logic        reset;
    logic [2:0]  info_load;
    logic [1:0]  info_store;
    logic [31:0] alu_result;
    logic [31:0] rs2;
    logic        write_reg;
    logic [4:0]  dst_addr;
    logic [31:0] next_pc;
    logic [31:0] hc_OUT_data;
    logic [31:0] next_pcD;
    logic        w_reg;
    logic [31:0] rd_data;
    logic [31:0] branchD;
    logic [4:0]  dst_addrD;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [2:0]  ld;
        logic [1:0]  st;
        logic [31:0] alu;
        logic [31:0] data;
        logic [31:0] hc;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    mem_access_stage #(
        .DMEM_WORDS (DMEM_WORDS),
        .DMEM_AW    (DMEM_AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .info_load   (info_load),
        .info_store  (info_store),
        .alu_result  (alu_result),
        .rs2         (rs2),
        .write_reg   (write_reg),
        .dst_addr    (dst_addr),
        .next_pc     (next_pc),
        .hc_OUT_data (hc_OUT_data),
        .next_pcD    (next_pcD),
        .w_reg       (w_reg),
        .rd_data     (rd_data),
        .branchD     (branchD),
        .dst_addrD   (dst_addrD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " next_pcD"},  next_pcD, 32'h0);
        chk({tag, " w_reg"},     {31'h0, w_reg}, 32'h0);
        chk({tag, " rd_data"},   rd_data, 32'h0);
        chk({tag, " branchD"},   branchD, 32'h0);
        chk({tag, " dst_addrD"}, {27'h0, dst_addrD}, 32'h0);
    endtask

    task automatic add(input string n, input logic [2:0] ld, input logic [1:0] st,
                       input logic [31:0] alu, input logic [31:0] data,
                       input logic [31:0] hc, input logic [31:0] exp_rd);
        vec_t v;
        v.name = n; v.ld = ld; v.st = st; v.alu = alu;
        v.data = data; v.hc = hc; v.exp_rd = exp_rd;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] alu,
                         input logic [31:0] data, input logic [31:0] hc, input logic wr,
                         input logic [4:0] dst, input logic [31:0] npc);
        info_load   = ld;
        info_store  = st;
        alu_result  = alu;
        rs2         = data;
        hc_OUT_data = hc;
        write_reg   = wr;
        dst_addr    = dst;
        next_pc     = npc;
    endtask

    initial begin
        logic [31:0] npc;
        logic [4:0]  dst;
        logic        wr;

        add("sw_dead",    NOTLOAD, SW,       32'h0000_0100, 32'hDEAD_BEEF, 32'hFEED_FACE, 32'h0000_0100);
        add("lw_dead",    LW,      NOTSTORE, 32'h0000_0100, 32'h0,         32'hFEED_FACE, 32'hDEAD_BEEF);
        add("lb_103",     LB,      NOTSTORE, 32'h0000_0103, 32'h0,         32'hFEED_FACE, 32'hFFFF_FFDE);
        add("lbu_103",    LBU,     NOTSTORE, 32'h0000_0103, 32'h0,         32'hFEED_FACE, 32'h0000_00DE);
        add("lh_102",     LH,      NOTSTORE, 32'h0000_0102, 32'h0,         32'hFEED_FACE, 32'hFFFF_DEAD);
        add("lhu_100",    LHU,     NOTSTORE, 32'h0000_0100, 32'h0,         32'hFEED_FACE, 32'h0000_BEEF);
        add("sb_101",     NOTLOAD, SB,       32'h0000_0101, 32'h1122_335A, 32'hFEED_FACE, 32'h0000_0101);
        add("lw_after_sb",LW,      NOTSTORE, 32'h0000_0100, 32'h0,         32'hFEED_FACE, 32'hDEAD_5AEF);
        add("sh_102",     NOTLOAD, SH,       32'h0000_0102, 32'hFFFF_1234, 32'hFEED_FACE, 32'h0000_0102);
        add("lw_after_sh",LW,      NOTSTORE, 32'h0000_0100, 32'h0,         32'hFEED_FACE, 32'h1234_5AEF);
        add("lw_ign_lsb", LW,      NOTSTORE, 32'h0000_0103, 32'h0,         32'hFEED_FACE, 32'h1234_5AEF);
        add("lh_101",     LH,      NOTSTORE, 32'h0000_0101, 32'h0,         32'hFEED_FACE, 32'h0000_5AEF);
        add("lhu_103",    LHU,     NOTSTORE, 32'h0000_0103, 32'h0,         32'hFEED_FACE, 32'h0000_1234);
        add("lb_100",     LB,      NOTSTORE, 32'h0000_0100, 32'h0,         32'hFEED_FACE, 32'hFFFF_FFEF);
        add("lb_101",     LB,      NOTSTORE, 32'h0000_0101, 32'h0,         32'hFEED_FACE, 32'h0000_005A);
        add("nonload_42", NOTLOAD, NOTSTORE, 32'h0000_0042, 32'h0,         32'hFEED_FACE, 32'h0000_0042);
        add("lw_hc",      LW,      NOTSTORE, 32'hFFFF_FF00, 32'h0,         32'h0000_1234, 32'h0000_1234);
        add("lb_hc",      LB,      NOTSTORE, 32'hFFFF_FF00, 32'h0,         32'h0000_0080, 32'h0000_0080);
        add("sw_f070",    NOTLOAD, SW,       32'h0000_F070, 32'h1122_3344, 32'hFEED_FACE, 32'h0000_F070);
        add("sw_uart",    NOTLOAD, SW,       32'hF6FF_F070, 32'hCAFE_F00D, 32'hFEED_FACE, 32'hF6FF_F070);
        add("lw_f070",    LW,      NOTSTORE, 32'h0000_F070, 32'h0,         32'hFEED_FACE, 32'h1122_3344);
        add("sw_ff00",    NOTLOAD, SW,       32'h0000_FF00, 32'h0000_0055, 32'hFEED_FACE, 32'h0000_FF00);
        add("sw_hc",      NOTLOAD, SW,       32'hFFFF_FF00, 32'h0000_0099, 32'hFEED_FACE, 32'hFFFF_FF00);
        add("lw_ff00",    LW,      NOTSTORE, 32'h0000_FF00, 32'h0,         32'hFEED_FACE, 32'h0000_0055);
        add("sw_wrap",    NOTLOAD, SW,       32'h0001_0000, 32'hA5A5_A5A5, 32'hFEED_FACE, 32'h0001_0000);
        add("lw_0",       LW,      NOTSTORE, 32'h0000_0000, 32'h0,         32'hFEED_FACE, 32'hA5A5_A5A5);
        add("ld_undef",   3'd6,    NOTSTORE, 32'h0000_0100, 32'h0,         32'hFEED_FACE, 32'h0000_0100);
        add("sw_200",     NOTLOAD, SW,       32'h0000_0200, 32'h0000_0001, 32'hFEED_FACE, 32'h0000_0200);
        add("ld_st_same", LW,      SW,       32'h0000_0200, 32'h0000_0002, 32'hFEED_FACE, 32'h0000_0001);
        add("lw_200",     LW,      NOTSTORE, 32'h0000_0200, 32'h0,         32'hFEED_FACE, 32'h0000_0002);

        reset = 1'b0;
        drive(NOTLOAD, NOTSTORE, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(posedge clk); #1;
        chk_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            npc = 32'h0000_2000 + 32'(i) * 4;
            dst = 5'(i + 1);
            wr  = i[0];
            if (vecs[i].name == "nonload_42") begin
                npc = 32'h0000_2004; dst = 5'd7; wr = 1'b1;
            end
            @(negedge clk);
            drive(vecs[i].ld, vecs[i].st, vecs[i].alu, vecs[i].data, vecs[i].hc, wr, dst, npc);
            @(posedge clk); #1;
            chk({vecs[i].name, " rd_data"},   rd_data, vecs[i].exp_rd);
            chk({vecs[i].name, " branchD"},   branchD, vecs[i].alu);
            chk({vecs[i].name, " next_pcD"},  next_pcD, npc);
            chk({vecs[i].name, " w_reg"},     {31'h0, w_reg}, {31'h0, wr});
            chk({vecs[i].name, " dst_addrD"}, {27'h0, dst_addrD}, {27'h0, dst});
        end

        // Asynchronous reset mid-cycle, then a store attempted while held in reset.
        @(negedge clk);
        drive(NOTLOAD, NOTSTORE, 32'h0000_0077, 32'h0, 32'h0, 1'b1, 5'd9, 32'h0000_3000);
        @(posedge clk); #1;
        chk("pre_rst branchD", branchD, 32'h0000_0077);
        #2;
        reset = 1'b0;
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        drive(NOTLOAD, SW, 32'h0000_0100, 32'hBADB_AD00, 32'h0, 1'b1, 5'd3, 32'h0000_4000);
        @(posedge clk); #1;
        chk_zero("held_rst");
        @(negedge clk);
        reset = 1'b1;
        drive(LW, NOTSTORE, 32'h0000_0100, 32'h0, 32'hFEED_FACE, 1'b0, 5'd0, 32'h0);
        @(posedge clk); #1;
        chk("rst_no_write rd_data", rd_data, 32'h1234_5AEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
